// File: rtl/ps2_device_tx_if.sv
//------------------------------------------------------------------------------
// ps2_device_tx_if
//   Byte handshake between a byte source and the PS/2 device-side transmitter.
//
//   tx_data  [7:0] source -> tx   byte to send
//   tx_valid       source -> tx   a byte is offered
//   tx_ready       tx -> source   the transmitter can take a byte
//   tx_done        tx -> source   one-cycle pulse after a frame completes
//   tx_abort       tx -> source   one-cycle pulse when the host inhibits a frame
//
//   master: the byte source.  slave: the transmitter.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface ps2_device_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_abort;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  tx_abort
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output tx_abort
  );
endinterface

// File: rtl/ps2_device_tx.sv
//------------------------------------------------------------------------------
// ps2_device_tx
//   Device (keyboard) end of a PS/2 link. Takes bytes over a valid/ready
//   handshake and sends standard 11-bit frames (start 0, 8 data bits LSB first,
//   odd parity, stop 1) by pulling PS2_CLK / PS2_DAT low open-drain. A host
//   that holds the clock low before or during a frame is honoured: the frame
//   waits for the bus, or is aborted and retried from its start bit.
//
// Parameters
//   CLK_HALF   clk cycles per PS/2 clock half-period
//   IDLE_HIGH  cycles both lines must read high before a frame starts
//
// Ports
//   clk          system clock (single domain)
//   reset        synchronous, active-high
//   tx           byte handshake (slave side): tx_data, tx_valid, tx_ready,
//                tx_done, tx_abort
//   ps2_clk_in   PS2_CLK pad value (asynchronous)
//   ps2_dat_in   PS2_DAT pad value (asynchronous)
//   ps2_clk_oe   1 pulls PS2_CLK low
//   ps2_dat_oe   1 pulls PS2_DAT low
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module ps2_device_tx #(
  parameter int CLK_HALF  = 2000,
  parameter int IDLE_HIGH = 2500
) (
  input  logic               clk,
  input  logic               reset,
  ps2_device_tx_if.slave     tx,
  input  logic               ps2_clk_in,
  input  logic               ps2_dat_in,
  output logic               ps2_clk_oe,
  output logic               ps2_dat_oe
);

  localparam int PH_W   = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int IDLE_W = $clog2(IDLE_HIGH + 3);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_HALF - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(CLK_HALF / 2);

  // The bus-idle window is stretched by the synchronizer depth so that the
  // pads themselves, not just their delayed copies, have been high for the
  // whole IDLE_HIGH window when the first clock half starts.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_HIGH + 2);

  localparam logic [3:0] IDX_STOP = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BUS,
    S_BIT_HIGH,
    S_BIT_LOW,
    S_FINISH,
    S_ABORT
  } state_t;

  state_t            state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [3:0]        idx_q, idx_d;
  logic              dat_oe_q, dat_oe_d;
  logic              done_q, done_d;
  logic [10:0]       frame_q, frame_d;

  logic sclk_meta_q, sclk_q;
  logic sdat_meta_q, sdat_q;
  logic tx_ready;
  logic bus_idle;

  // Two-flop synchronizers; they reset to the idle (released) line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_meta_q <= 1'b1;
      sclk_q      <= 1'b1;
      sdat_meta_q <= 1'b1;
      sdat_q      <= 1'b1;
    end else begin
      sclk_meta_q <= ps2_clk_in;
      sclk_q      <= sclk_meta_q;
      sdat_meta_q <= ps2_dat_in;
      sdat_q      <= sdat_meta_q;
    end
  end

  assign bus_idle = sclk_q & sdat_q;

  // A byte is never taken while a frame is pending, nor in the cycle that
  // reports the previous frame's completion.
  assign tx_ready = (state_q == S_IDLE) && !done_q;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    dat_oe_d   = dat_oe_q;
    done_d     = 1'b0;
    frame_d    = frame_q;

    case (state_q)
      S_IDLE: begin
        idle_cnt_d = '0;
        dat_oe_d   = 1'b0;
        if (tx.tx_valid && tx_ready) begin
          frame_d = {1'b1, ~^tx.tx_data, tx.tx_data, 1'b0};
          state_d = S_WAIT_BUS;
        end
      end

      // A low data line here is a host request-to-send; it simply keeps the
      // idle counter at zero until the host lets go.
      S_WAIT_BUS: begin
        dat_oe_d = 1'b0;
        if (bus_idle) begin
          if (idle_cnt_q == IDLE_LAST) begin
            idle_cnt_d = '0;
            phase_d    = '0;
            idx_d      = 4'd0;
            state_d    = S_BIT_HIGH;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end

      // Data is changed mid-high so it is stable around both clock edges.
      S_BIT_HIGH: begin
        if (phase_q == PH_MID) begin
          dat_oe_d = ~frame_q[idx_q];
        end
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          // Clock still low after our release means the host is inhibiting.
          // Once the stop bit is on the wire the frame is allowed to finish.
          if (!sclk_q && (idx_q < IDX_STOP)) begin
            state_d = S_ABORT;
          end else begin
            state_d = S_BIT_LOW;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      S_BIT_LOW: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (idx_q == IDX_STOP) begin
            dat_oe_d = 1'b0;
            state_d  = S_FINISH;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_BIT_HIGH;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      S_FINISH: begin
        dat_oe_d = 1'b0;
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      // Single-cycle state: report the abort, then retry the latched frame.
      S_ABORT: begin
        dat_oe_d   = 1'b0;
        idle_cnt_d = '0;
        phase_d    = '0;
        idx_d      = 4'd0;
        state_d    = S_WAIT_BUS;
      end

      default: begin
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
      phase_q    <= '0;
      idx_q      <= 4'd0;
      dat_oe_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      dat_oe_q   <= dat_oe_d;
      done_q     <= done_d;
    end
  end

  // Frame contents carry no reset; they are only read while a frame is active.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  // Drivers decode the state directly so every exit from the bit states
  // (finish, abort, reset) releases both lines in the same cycle.
  assign ps2_clk_oe  = (state_q == S_BIT_LOW);
  assign ps2_dat_oe  = dat_oe_q && ((state_q == S_BIT_HIGH) || (state_q == S_BIT_LOW));

  assign tx.tx_ready = tx_ready;
  assign tx.tx_done  = done_q;
  assign tx.tx_abort = (state_q == S_ABORT);

endmodule

// File: tb/tb_ps2_device_tx.sv
//------------------------------------------------------------------------------
// tb_ps2_device_tx
//   Directed bench for ps2_device_tx with CLK_HALF=8, IDLE_HIGH=16. A host
//   model captures PS2_DAT on every falling PS2_CLK edge the device drives and
//   can pull PS2_CLK low to inhibit.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_device_tx;

  localparam int CLK_HALF  = 8;
  localparam int IDLE_HIGH = 16;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk_oe, ps2_dat_oe;
  logic host_clk_pull = 1'b0;
  logic ps2_clk_line, ps2_dat_line;

  always #5 clk = ~clk;

  ps2_device_tx_if tx_if ();

  assign ps2_clk_line = ~(ps2_clk_oe | host_clk_pull);
  assign ps2_dat_line = ~ps2_dat_oe;

  ps2_device_tx #(
    .CLK_HALF  (CLK_HALF),
    .IDLE_HIGH (IDLE_HIGH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx         (tx_if),
    .ps2_clk_in (ps2_clk_line),
    .ps2_dat_in (ps2_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  // Edge-stamped event log. cyc is the index of the clk edge being processed.
  int cyc = 0;
  int xfer_cnt = 0, xfer_cyc = 0;
  int done_cnt = 0, done_cyc = 0;
  int abort_cnt = 0, both_cnt = 0, oe_hi_cnt = 0;
  logic ready_at_done = 1'b1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_if.tx_valid && tx_if.tx_ready) begin
      xfer_cnt <= xfer_cnt + 1;
      xfer_cyc <= cyc;
    end
    if (tx_if.tx_done) begin
      done_cnt      <= done_cnt + 1;
      done_cyc      <= cyc;
      ready_at_done <= tx_if.tx_ready;
    end
    if (tx_if.tx_abort) abort_cnt <= abort_cnt + 1;
    if (tx_if.tx_done && tx_if.tx_abort) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe || ps2_dat_oe) oe_hi_cnt <= oe_hi_cnt + 1;
  end

  // Host receiver: one bit per device-driven falling clock edge, LSB first.
  logic [10:0] rx_bits = '0;
  int rx_n = 0, rise_cyc = 0;

  always @(posedge ps2_clk_oe) begin
    rx_bits  <= {ps2_dat_line, rx_bits[10:1]};
    rx_n     <= rx_n + 1;
    rise_cyc <= cyc;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_ge(input string tag, input int got, input int min);
    n_checks++;
    assert (got >= min) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected >= %0d", tag, got, min);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_xfer(input int base, input string tag);
    int n = 0;
    while (xfer_cnt == base && n < 200) begin @(negedge clk); n++; end
    check(tag, int'(xfer_cnt != base), 1);
  endtask

  task automatic wait_done(input int base, input int budget, input string tag);
    int n = 0;
    while (done_cnt == base && n < budget) begin @(negedge clk); n++; end
    check(tag, int'(done_cnt != base), 1);
  endtask

  task automatic wait_rx(input int target, input string tag);
    int n = 0;
    while (rx_n < target && n < 600) begin @(negedge clk); n++; end
    check(tag, int'(rx_n >= target), 1);
  endtask

  task automatic wait_clk_release(input string tag);
    int n = 0;
    while (ps2_clk_oe !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check(tag, int'(ps2_clk_oe === 1'b0), 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    int base;
    base = xfer_cnt;
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    wait_xfer(base, tag);
    tx_if.tx_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1, a0, r0, x0, oe0, first_rise, rel, n;

    reset          = 1'b1;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);

    // ---- reset state ----
    check("rst_ready", int'(tx_if.tx_ready), 1);
    check("rst_done",  int'(tx_if.tx_done),  0);
    check("rst_abort", int'(tx_if.tx_abort), 0);
    check("rst_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_dat_oe", int'(ps2_dat_oe), 0);
    step(30);
    check("idle_no_oe", oe_hi_cnt, 0);

    // ---- 0x1C: bits 0,0,0,1,1,1,0,0,0,0,1 ----
    d0 = done_cnt; r0 = rx_n;
    send_byte(8'h1C, "x1c_xfer");
    step(1);
    check("x1c_ready_low", int'(tx_if.tx_ready), 0);
    wait_rx(r0 + 1, "x1c_first_bit");
    first_rise = rise_cyc;
    // clk_oe first asserts IDLE_HIGH+CLK_HALF+3 edges after the transfer at
    // the earliest; the rise is stamped one edge later.
    check_ge("x1c_start_latency", first_rise - xfer_cyc, IDLE_HIGH + CLK_HALF + 4);
    wait_done(d0, 600, "x1c_done_seen");
    check("x1c_frame", int'(rx_bits), 11'h438);
    check("x1c_bits", rx_n - r0, 11);
    // First BIT_HIGH starts CLK_HALF before the first clock low.
    check("x1c_done_time", done_cyc - first_rise, 23 * CLK_HALF - CLK_HALF);
    step(40);
    check("x1c_done_once", done_cnt - d0, 1);

    // ---- 0x00 then 0xFF with valid held ----
    d0 = done_cnt;
    x0 = xfer_cnt;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b1;
    wait_xfer(x0, "b2b_xfer1");
    tx_if.tx_data = 8'hFF;
    wait_done(d0, 600, "b2b_done1");
    d1 = done_cyc;
    check("b2b_frame00", int'(rx_bits), 11'h600);
    check("b2b_ready_at_done", int'(ready_at_done), 0);
    wait_xfer(x0 + 1, "b2b_xfer2");
    tx_if.tx_valid = 1'b0;
    check("b2b_accept_gap", xfer_cyc - d1, 1);
    r0 = rx_n;
    wait_rx(r0 + 1, "b2b_first_bit2");
    check_ge("b2b_idle_gap", rise_cyc - d1, IDLE_HIGH + 1);
    wait_done(d0 + 1, 600, "b2b_done2");
    check("b2b_frameff", int'(rx_bits), 11'h7FE);
    step(40);

    // ---- pre-start inhibit ----
    host_clk_pull = 1'b1;
    step(2);
    d0 = done_cnt; a0 = abort_cnt; oe0 = oe_hi_cnt; r0 = rx_n;
    send_byte(8'h5A, "pre_xfer");
    step(60);
    check("pre_no_oe", oe_hi_cnt - oe0, 0);
    rel = cyc;
    host_clk_pull = 1'b0;
    wait_rx(r0 + 1, "pre_first_bit");
    check_ge("pre_release_gap", rise_cyc - rel, IDLE_HIGH + 1);
    wait_done(d0, 600, "pre_done");
    check("pre_frame", int'(rx_bits), 11'h6B4);
    check("pre_no_abort", abort_cnt - a0, 0);
    step(40);

    // ---- mid-frame inhibit during data bit 4 ----
    d0 = done_cnt; a0 = abort_cnt; r0 = rx_n;
    send_byte(8'h5A, "mid_xfer");
    wait_rx(r0 + 5, "mid_reach_bit4");
    wait_clk_release("mid_bit4_high");
    step(2);
    host_clk_pull = 1'b1;
    n = 0;
    while (tx_if.tx_abort !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    check("mid_abort_seen", int'(tx_if.tx_abort), 1);
    check("mid_abort_clk_oe", int'(ps2_clk_oe), 0);
    check("mid_abort_dat_oe", int'(ps2_dat_oe), 0);
    check("mid_abort_ready", int'(tx_if.tx_ready), 0);
    oe0 = oe_hi_cnt;
    step(20);
    check("mid_abort_once", abort_cnt - a0, 1);
    check("mid_held_no_oe", oe_hi_cnt - oe0, 0);
    host_clk_pull = 1'b0;
    wait_done(d0, 600, "mid_done");
    check("mid_resent_frame", int'(rx_bits), 11'h6B4);
    check("mid_abort_total", abort_cnt - a0, 1);
    step(40);

    // ---- inhibit during stop bit is ignored ----
    d0 = done_cnt; a0 = abort_cnt; r0 = rx_n;
    send_byte(8'h1C, "stop_xfer");
    wait_rx(r0 + 1, "stop_first_bit");
    first_rise = rise_cyc;
    wait_rx(r0 + 10, "stop_reach_parity");
    wait_clk_release("stop_bit_high");
    step(2);
    host_clk_pull = 1'b1;
    wait_done(d0, 100, "stop_done");
    host_clk_pull = 1'b0;
    check("stop_no_abort", abort_cnt - a0, 0);
    check("stop_done_time", done_cyc - first_rise, 23 * CLK_HALF - CLK_HALF);
    check("stop_frame", int'(rx_bits), 11'h438);
    step(40);

    // ---- reset mid-frame during data bit 6 of 0xF0 ----
    r0 = rx_n;
    send_byte(8'hF0, "rstmid_xfer");
    wait_rx(r0 + 7, "rstmid_reach_bit6");
    wait_clk_release("rstmid_bit6_high");
    step(3);
    reset = 1'b1;
    step(1);
    check("rstmid_clk_oe", int'(ps2_clk_oe), 0);
    check("rstmid_dat_oe", int'(ps2_dat_oe), 0);
    check("rstmid_ready", int'(tx_if.tx_ready), 1);
    reset = 1'b0;
    d0 = done_cnt; a0 = abort_cnt; oe0 = oe_hi_cnt; r0 = rx_n;
    step(100);
    check("rstmid_no_done", done_cnt - d0, 0);
    check("rstmid_no_abort", abort_cnt - a0, 0);
    check("rstmid_line_idle", oe_hi_cnt - oe0, 0);
    check("rstmid_no_bits", rx_n - r0, 0);

    check("done_abort_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
